decoder_scan_n: RTL and testbench

//  Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable.
//  Two modes: DIRECT decodes sel; SCAN auto-steps the active output through
//  all 2^SEL_W lines, holding each for a programmable dwell time.

---
 rtl/decoder_scan_n.sv | 175 +++++++++++++++++
 tb/tb_decoder_scan_n.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_n.sv
// decoder_scan_n
//   Registered SEL_W-to-2^SEL_W one-hot decoder with enable, for digit/row
//   strobes of multiplexed displays and scanned keypads.
//   DIRECT mode decodes sel with one clock of latency. SCAN mode walks the
//   active line through every output, holding each for dwell+1 cycles.
//
// Parameters
//   SEL_W    select width; OUT_W = 2**SEL_W output lines
//   DWELL_W  width of the dwell input and dwell counter
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       1: outputs active, 0: y forced to zero (state returns to IDLE)
//   mode     0: DIRECT, 1: SCAN
//   sel      select index used in DIRECT mode
//   dwell    SCAN hold time minus one, sampled live every cycle
//   y        registered one-hot output, all-zero when idle or blanking
//   cur_sel  index currently driven on y (next index while blanking)
//   wrap     one-cycle pulse when the scan shows index 0 after OUT_W-1
//
// Configuration
//   DEC_BLANK_EN  when defined, SCAN inserts one all-zero BLANK cycle
//                 between consecutive lines to suppress ghosting.
module decoder_scan_n #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIRECT = 2'd1,
    S_SCAN   = 2'd2,
    S_BLANK  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]   y_d;
  logic [SEL_W-1:0]   cur_sel_d;
  logic               wrap_d;

  logic               step;
  logic [SEL_W-1:0]   next_idx;

  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] s);
    dec = OUT_W'(1) << s;
  endfunction

  // Compare with >= so that lowering dwell below the running count
  // advances on the very next cycle instead of waiting for a counter wrap.
  assign step     = (state_q == S_SCAN) && (cnt_q >= dwell);
  // Natural SEL_W-bit overflow gives the OUT_W-1 -> 0 wrap for free.
  assign next_idx = cur_sel_q_plus1();

  function automatic logic [SEL_W-1:0] cur_sel_q_plus1();
    cur_sel_q_plus1 = cur_sel + SEL_W'(1);
  endfunction

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = mode ? S_SCAN : S_DIRECT;
        S_DIRECT: if (mode) state_d = S_SCAN;
        S_SCAN: begin
          if (!mode) state_d = S_DIRECT;
`ifdef DEC_BLANK_EN
          else if (step) state_d = S_BLANK;
`endif
        end
        // The blank slot always returns to the scan unless mode dropped.
        S_BLANK:  state_d = mode ? S_SCAN : S_DIRECT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output logic: next values of the registered outputs, keyed on the
  // transition so every output lands in the same cycle as the new state.
  // ---------------------------------------------------------------------
  always_comb begin
    y_d       = '0;
    cur_sel_d = cur_sel;
    cnt_d     = cnt_q;
    wrap_d    = 1'b0;
    case (state_d)
      S_IDLE: begin
        cur_sel_d = '0;
        cnt_d     = '0;
      end
      S_DIRECT: begin
        cur_sel_d = sel;
        cnt_d     = '0;
        y_d       = dec(sel);
      end
      S_SCAN: begin
        if (state_q == S_SCAN) begin
          if (step) begin
            cur_sel_d = next_idx;
            cnt_d     = '0;
            y_d       = dec(next_idx);
            wrap_d    = (next_idx == '0);
          end else begin
            cnt_d     = cnt_q + DWELL_W'(1);
            y_d       = dec(cur_sel);
          end
        end else if (state_q == S_BLANK) begin
          // cur_sel already advanced on entry to BLANK.
          cnt_d  = '0;
          y_d    = dec(cur_sel);
          wrap_d = (cur_sel == '0);
        end else begin
          // Fresh entry from IDLE or DIRECT always restarts at line 0
          // and never flags a wrap.
          cur_sel_d = '0;
          cnt_d     = '0;
          y_d       = dec('0);
        end
      end
      S_BLANK: begin
        cur_sel_d = next_idx;
        cnt_d     = '0;
      end
      default: begin
        cur_sel_d = '0;
        cnt_d     = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      cur_sel <= '0;
      wrap    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y       <= y_d;
      cur_sel <= cur_sel_d;
      wrap    <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan_n.sv
module tb_decoder_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;

  logic       en_a, mode_a;
  logic [1:0] sel_a;
  logic [7:0] dwell_a;
  logic [3:0] y_a;
  logic [1:0] cs_a;
  logic       wrap_a;

  logic       en_b, mode_b;
  logic [2:0] sel_b;
  logic [7:0] dwell_b;
  logic [7:0] y_b;
  logic [2:0] cs_b;
  logic       wrap_b;

  int  passed = 0;
  int  total  = 0;
  bit  inv_on = 1'b0;

  decoder_scan_n #(.SEL_W(2), .DWELL_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a),
    .dwell(dwell_a), .y(y_a), .cur_sel(cs_a), .wrap(wrap_a)
  );

  decoder_scan_n #(.SEL_W(3), .DWELL_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b),
    .dwell(dwell_b), .y(y_b), .cur_sel(cs_b), .wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs must never show more than one active line.
  always @(negedge clk) begin
    if (inv_on) begin
      total++;
      assert ($onehot0(y_a) && $onehot0(y_b)) passed++;
      else $error("FAIL onehot: y_a %b y_b %b", y_a, y_b);
    end
  end

  initial begin
    en_a = 0; mode_a = 0; sel_a = 0; dwell_a = 0;
    en_b = 0; mode_b = 0; sel_b = 0; dwell_b = 0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_y_a",    32'(y_a),    32'h0);
    chk("rst_cs_a",   32'(cs_a),   32'h0);
    chk("rst_wrap_a", 32'(wrap_a), 32'h0);
    chk("rst_y_b",    32'(y_b),    32'h0);
    inv_on = 1'b1;
    rst_n = 1'b1;

    // DIRECT decode, one clock from sel to y
    en_a = 1; mode_a = 0;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      tick();
      chk("direct_y",    32'(y_a),    32'(1 << s));
      chk("direct_cs",   32'(cs_a),   32'(s));
      chk("direct_wrap", 32'(wrap_a), 32'h0);
    end
    en_a = 0;
    tick();
    chk("direct_off_y", 32'(y_a), 32'h0);

`ifndef DEC_BLANK_EN
    // SCAN dwell=2: 3 cycles per line, wrap every 12
    dwell_a = 2; mode_a = 1; en_a = 1;
    for (int k = 0; k < 25; k++) begin
      tick();
      chk("scan2_y",    32'(y_a),    32'(1 << ((k / 3) % 4)));
      chk("scan2_wrap", 32'(wrap_a), 32'((k > 0) && (k % 12 == 0)));
    end
    en_a = 0;
    tick();
    chk("scan2_off_y",    32'(y_a),    32'h0);
    chk("scan2_off_wrap", 32'(wrap_a), 32'h0);

    // SCAN dwell=0: step every clock, then mid-scan switch to DIRECT
    dwell_a = 0; en_a = 1; mode_a = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("scan0_y",    32'(y_a),    32'(1 << (k % 4)));
      chk("scan0_wrap", 32'(wrap_a), 32'(k == 4));
    end
    mode_a = 0; sel_a = 2;
    tick();
    chk("sw_direct_y",    32'(y_a),    32'h4);
    chk("sw_direct_wrap", 32'(wrap_a), 32'h0);
    chk("sw_direct_cs",   32'(cs_a),   32'h2);
    // back to SCAN restarts at line 0 without a wrap pulse
    mode_a = 1;
    tick();
    chk("sw_scan_y",    32'(y_a),    32'h1);
    chk("sw_scan_wrap", 32'(wrap_a), 32'h0);
    chk("sw_scan_cs",   32'(cs_a),   32'h0);
    // lowering dwell below the running count advances next cycle
    dwell_a = 5;
    tick(); tick(); tick();
    chk("dwell_hold_y", 32'(y_a), 32'h1);
    dwell_a = 1;
    tick();
    chk("dwell_low_y0", 32'(y_a), 32'h2);
    tick();
    chk("dwell_low_y1", 32'(y_a), 32'h2);
    tick();
    chk("dwell_low_y2", 32'(y_a), 32'h4);

    // SEL_W=3, dwell=1: 8 lines x 2 clocks, wrap every 16
    dwell_b = 1; mode_b = 1; en_b = 1;
    for (int k = 0; k < 34; k++) begin
      tick();
      chk("b_scan_y",    32'(y_b),    32'(1 << ((k / 2) % 8)));
      chk("b_scan_wrap", 32'(wrap_b), 32'((k > 0) && (k % 16 == 0)));
    end
    en_b = 0;
    tick();
    chk("b_off_y", 32'(y_b), 32'h0);
`else
    // SCAN with blanking, dwell=1: two active cycles then one blank
    dwell_a = 1; mode_a = 1; en_a = 1;
    for (int k = 0; k < 26; k++) begin
      tick();
      chk("blank_y",    32'(y_a),    ((k % 3) < 2) ? 32'(1 << ((k / 3) % 4)) : 32'h0);
      chk("blank_cs",   32'(cs_a),   ((k % 3) < 2) ? 32'((k / 3) % 4) : 32'(((k / 3) + 1) % 4));
      chk("blank_wrap", 32'(wrap_a), 32'((k == 12) || (k == 24)));
    end
`endif

    // Reset in the middle of a scan clears outputs asynchronously
    en_a = 0;
    tick();
    dwell_a = 3; mode_a = 1; en_a = 1;
    repeat (6) tick();
    chk("pre_rst_y", 32'(y_a), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y",    32'(y_a),    32'h0);
    chk("async_rst_cs",   32'(cs_a),   32'h0);
    chk("async_rst_wrap", 32'(wrap_a), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_y",    32'(y_a),    32'h1);
    chk("restart_cs",   32'(cs_a),   32'h0);
    chk("restart_wrap", 32'(wrap_a), 32'h0);

    inv_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
